// File: rtl/apb_master_bridge.sv
// apb_master_bridge: converts single command/response transactions into APB4
// SETUP/ACCESS transfers. One transfer outstanding at a time. Wait states and
// PSLVERR are supported.
// Optional feature macro: APB_MASTER_TIMEOUT_EN
//   defined   - a PREADY timeout abandons an ACCESS phase after
//               TIMEOUT_CYCLES consecutive cycles with pready low
//   undefined - ACCESS waits indefinitely and rsp_timeout_o is tied low
module apb_master_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      pclk_i,
    input  logic                      preset_i,
    // command side
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic                      cmd_write_i,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr_i,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]   cmd_strb_i,
    input  logic [2:0]                cmd_prot_i,
    // response side
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [DATA_WIDTH-1:0]     rsp_rdata_o,
    output logic                      rsp_err_o,
    output logic                      rsp_timeout_o,
    // APB4 initiator
    output logic [ADDR_WIDTH-1:0]     paddr_o,
    output logic [2:0]                pprot_o,
    output logic                      pwrite_o,
    output logic [DATA_WIDTH-1:0]     pwdata_o,
    output logic [DATA_WIDTH/8-1:0]   pstrb_o,
    output logic                      psel_o,
    output logic                      penable_o,
    input  logic [DATA_WIDTH-1:0]     prdata_i,
    input  logic                      pready_i,
    input  logic                      pslverr_i
);

    // Parameter sanity, caught at elaboration.
    if (DATA_WIDTH % 8 != 0) begin : g_bad_dw
        $error("apb_master_bridge: DATA_WIDTH must be a multiple of 8");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_tmo
        $error("apb_master_bridge: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                    state_q;
    logic                      cmd_ready_q;
    logic                      rsp_valid_q;
    logic [DATA_WIDTH-1:0]     rsp_rdata_q;
    logic                      rsp_err_q;
    logic [ADDR_WIDTH-1:0]     paddr_q;
    logic [2:0]                pprot_q;
    logic                      pwrite_q;
    logic [DATA_WIDTH-1:0]     pwdata_q;
    logic [DATA_WIDTH/8-1:0]   pstrb_q;
    logic                      psel_q;
    logic                      penable_q;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // The count value that, with one more pready-low sample, reaches the limit.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tmo_cnt_q;
    logic             rsp_timeout_q;
    logic             tmo_hit_d;

    // This pready-low sample is the one that exhausts the wait budget.
    assign tmo_hit_d     = (tmo_cnt_q == TMO_LAST);
    assign rsp_timeout_o = rsp_timeout_q;
`else
    assign rsp_timeout_o = 1'b0;
`endif

    // Bridge FSM; every output is a register so nothing from the APB side
    // reaches the response port combinationally.
    always_ff @(posedge pclk_i or posedge preset_i) begin
        if (preset_i) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            paddr_q       <= '0;
            pprot_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            tmo_cnt_q     <= '0;
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        // Request fields are frozen here and held through ACCESS.
                        paddr_q     <= cmd_addr_i;
                        pprot_q     <= cmd_prot_i;
                        pwrite_q    <= cmd_write_i;
                        pwdata_q    <= cmd_wdata_i;
                        pstrb_q     <= cmd_write_i ? cmd_strb_i : '0;
                        psel_q      <= 1'b1;
                        cmd_ready_q <= 1'b0;
                        state_q     <= SETUP;
`ifdef APB_MASTER_TIMEOUT_EN
                        tmo_cnt_q   <= '0;
`endif
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    // A ready completion takes priority over the timeout.
                    if (pready_i) begin
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_err_q     <= pslverr_i;
                        rsp_rdata_q   <= (!pwrite_q && !pslverr_i) ? prdata_i : '0;
`ifdef APB_MASTER_TIMEOUT_EN
                        rsp_timeout_q <= 1'b0;
`endif
                        state_q       <= RESP;
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                    else if (tmo_hit_d) begin
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_err_q     <= 1'b1;
                        rsp_rdata_q   <= '0;
                        rsp_timeout_q <= 1'b1;
                        state_q       <= RESP;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
`endif
                end
                RESP: begin
                    // Response fields stay put until the consumer takes them.
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign paddr_o     = paddr_q;
    assign pprot_o     = pprot_q;
    assign pwrite_o    = pwrite_q;
    assign pwdata_o    = pwdata_q;
    assign pstrb_o     = pstrb_q;
    assign psel_o      = psel_q;
    assign penable_o   = penable_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: scenario tasks plus a randomized run against a
// transaction-level model of the bridge (latency, response fields, request
// fields). Timeout scenarios are built only with APB_MASTER_TIMEOUT_EN.
module tb_apb_master_bridge;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;
`ifdef APB_MASTER_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic            pclk = 1'b0;
    logic            preset;
    logic            cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0]   cmd_addr;
    logic [DW-1:0]   cmd_wdata;
    logic [DW/8-1:0] cmd_strb;
    logic [2:0]      cmd_prot;
    logic            rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [DW-1:0]   rsp_rdata;
    logic [AW-1:0]   paddr;
    logic [2:0]      pprot;
    logic            pwrite, psel, penable, pready, pslverr;
    logic [DW-1:0]   pwdata, prdata;
    logic [DW/8-1:0] pstrb;

    int total = 0;
    int bad   = 0;
    int cyc_cnt = 0;

    // Observations recorded by the driver for the scenario tasks to judge.
    bit            ob_expired, ob_setup_ok, ob_after_ok, ob_psel_at_rsp;
    int            ob_first_acc, ob_rsp_cyc, ob_field_bad, ob_hold_bad, ob_acc_time;
    logic [DW-1:0] ob_rdata;
    logic          ob_err, ob_tmo;

    apb_master_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .pclk_i(pclk), .preset_i(preset),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_strb_i(cmd_strb),
        .cmd_prot_i(cmd_prot),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_timeout),
        .paddr_o(paddr), .pprot_o(pprot), .pwrite_o(pwrite), .pwdata_o(pwdata),
        .pstrb_o(pstrb), .psel_o(psel), .penable_o(penable),
        .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc_cnt <= cyc_cnt + 1;

    // Model: cycle (after the accepting edge) in which the response appears.
    function automatic int exp_lat(input int waits);
        if (TMO_EN && waits >= TMO) return 2 + TMO;
        return 3 + waits;
    endfunction
    function automatic bit exp_tmo(input int waits);
        return TMO_EN && (waits >= TMO);
    endfunction

    // Drive one command and act as an APB slave that inserts 'waits' wait
    // states; hold rsp_ready low for 'bp' response cycles. Called and
    // returns at a negedge; only records what it sees.
    task automatic run_xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                            input logic [DW/8-1:0] strb, input logic [2:0] prot, input int waits,
                            input logic err, input logic [DW-1:0] rd, input int bp);
        int cyc, acc, held;
        bit done;
        logic [DW/8-1:0] xstrb;
        xstrb = wr ? strb : '0;
        ob_expired = 0; ob_setup_ok = 0; ob_after_ok = 0; ob_psel_at_rsp = 0;
        ob_first_acc = -1; ob_rsp_cyc = -1; ob_field_bad = 0; ob_hold_bad = 0;
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
        cmd_strb = strb; cmd_prot = prot; rsp_ready = 0;
        cyc = 0;
        while (!cmd_ready && cyc < 50) begin @(negedge pclk); cyc++; end
        if (!cmd_ready) begin ob_expired = 1; cmd_valid = 0; return; end
        ob_acc_time = cyc_cnt;
        @(negedge pclk);
        // Scramble the command bus so only the captured copy can be correct.
        cmd_valid = 0; cmd_addr = $urandom; cmd_wdata = $urandom;
        cmd_strb = DW/8'($urandom); cmd_prot = 3'($urandom); cmd_write = 1'($urandom);
        cyc = 1; acc = 0; held = 0; done = 0;
        while (!done && cyc < 200) begin
            if (cyc == 1) ob_setup_ok = psel && !penable;
            if (psel && (paddr !== addr || pwrite !== wr || pwdata !== wd ||
                         pstrb !== xstrb || pprot !== prot)) ob_field_bad++;
            if (psel && penable) begin
                if (ob_first_acc < 0) ob_first_acc = cyc;
                if (acc == waits) begin pready = 1; pslverr = err; prdata = rd; end
                else begin pready = 0; pslverr = 1'($urandom); prdata = $urandom; end
                acc++;
            end else begin
                pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
            end
            if (rsp_valid) begin
                if (ob_rsp_cyc < 0) begin
                    ob_rsp_cyc = cyc; ob_rdata = rsp_rdata; ob_err = rsp_err;
                    ob_tmo = rsp_timeout; ob_psel_at_rsp = psel;
                end else if (rsp_rdata !== ob_rdata || rsp_err !== ob_err ||
                             rsp_timeout !== ob_tmo) ob_hold_bad++;
                if (cmd_ready || psel || penable) ob_hold_bad++;
                rsp_ready = (held >= bp);
                held++;
            end else if (ob_rsp_cyc >= 0) begin
                ob_after_ok = cmd_ready && !psel;
                done = 1;
            end
            if (!done) begin @(negedge pclk); cyc++; end
        end
        if (!done) ob_expired = 1;
        rsp_ready = 0; pready = 0; pslverr = 0;
    endtask

    task automatic test_reset();
        preset = 1;
        @(negedge pclk);
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset cmd_ready: got %b want 1", cmd_ready); end
        total++; if ({rsp_valid, rsp_err, rsp_timeout, psel, penable, pwrite} !== 6'b0) begin bad++;
            $display("FAIL reset ctrl: got %b want 000000", {rsp_valid, rsp_err, rsp_timeout, psel, penable, pwrite}); end
        total++; if ({rsp_rdata, paddr, pwdata, pstrb, pprot} !== '0) begin bad++;
            $display("FAIL reset data: rdata=%h paddr=%h pwdata=%h pstrb=%h pprot=%h want 0", rsp_rdata, paddr, pwdata, pstrb, pprot); end
        preset = 0;
        @(negedge pclk);
        total++; if (cmd_ready !== 1'b1 || psel !== 1'b0) begin bad++;
            $display("FAIL reset release: cmd_ready=%b psel=%b want 1/0", cmd_ready, psel); end
    endtask

    task automatic test_write_zero_wait();
        run_xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b010, 0, 1'b0, 32'h0, 0);
        total++; if (ob_expired || !ob_setup_ok || ob_first_acc != 2) begin bad++;
            $display("FAIL wr0 phases: expired=%0d setup_ok=%0d first_access=%0d want 0/1/2", ob_expired, ob_setup_ok, ob_first_acc); end
        total++; if (ob_field_bad != 0) begin bad++; $display("FAIL wr0 apb fields: %0d bad cycles want 0", ob_field_bad); end
        total++; if (ob_rsp_cyc != 3 || ob_err !== 1'b0 || ob_rdata !== '0) begin bad++;
            $display("FAIL wr0 rsp: cyc=%0d err=%b rdata=%h want 3/0/0", ob_rsp_cyc, ob_err, ob_rdata); end
        total++; if (pwrite !== 1'b1 || pstrb !== 4'hF || paddr !== 32'h10) begin bad++;
            $display("FAIL wr0 hold: pwrite=%b pstrb=%h paddr=%h want 1/f/10", pwrite, pstrb, paddr); end
    endtask

    task automatic test_read_wait();
        run_xfer(1'b0, 32'h20, 32'hA5A5A5A5, 4'hF, 3'b000, 3, 1'b0, 32'h12345678, 0);
        total++; if (ob_expired || ob_rsp_cyc != 6) begin bad++;
            $display("FAIL rd3 latency: got cyc %0d want 6", ob_rsp_cyc); end
        total++; if (ob_rdata !== 32'h12345678 || ob_err !== 1'b0 || ob_tmo !== 1'b0) begin bad++;
            $display("FAIL rd3 rsp: rdata=%h err=%b tmo=%b want 12345678/0/0", ob_rdata, ob_err, ob_tmo); end
        total++; if (ob_field_bad != 0) begin bad++; $display("FAIL rd3 apb fields: %0d bad cycles want 0", ob_field_bad); end
    endtask

    task automatic test_slverr();
        run_xfer(1'b0, 32'h44, 32'h0, 4'h0, 3'b001, 0, 1'b1, 32'hFFFF0000, 0);
        total++; if (ob_err !== 1'b1 || ob_rdata !== '0 || ob_tmo !== 1'b0 || ob_rsp_cyc != 3) begin bad++;
            $display("FAIL slverr rsp: err=%b rdata=%h tmo=%b cyc=%0d want 1/0/0/3", ob_err, ob_rdata, ob_tmo, ob_rsp_cyc); end
    endtask

    task automatic test_backpressure();
        run_xfer(1'b0, 32'h88, 32'h0, 4'h0, 3'b100, 1, 1'b0, 32'hCAFEF00D, 5);
        total++; if (ob_hold_bad != 0) begin bad++; $display("FAIL backpressure hold: %0d bad cycles want 0", ob_hold_bad); end
        total++; if (ob_expired || !ob_after_ok || ob_rdata !== 32'hCAFEF00D) begin bad++;
            $display("FAIL backpressure release: expired=%0d after_ok=%0d rdata=%h want 0/1/cafef00d", ob_expired, ob_after_ok, ob_rdata); end
    endtask

    task automatic test_back_to_back();
        int t0;
        run_xfer(1'b1, 32'h100, 32'h11112222, 4'h3, 3'b000, 0, 1'b0, 32'h0, 0);
        t0 = ob_acc_time;
        run_xfer(1'b0, 32'h104, 32'h0, 4'hF, 3'b000, 0, 1'b0, 32'h33334444, 0);
        total++; if (ob_acc_time - t0 != 4) begin bad++;
            $display("FAIL back_to_back spacing: got %0d want 4", ob_acc_time - t0); end
        total++; if (ob_rdata !== 32'h33334444 || ob_field_bad != 0) begin bad++;
            $display("FAIL back_to_back rsp: rdata=%h fieldbad=%0d want 33334444/0", ob_rdata, ob_field_bad); end
    endtask

    task automatic test_timeout();
`ifdef APB_MASTER_TIMEOUT_EN
        run_xfer(1'b0, 32'h30, 32'h0, 4'h0, 3'b000, 1000, 1'b0, 32'h0, 0);
        total++; if (ob_expired || ob_rsp_cyc != 2 + TMO || ob_psel_at_rsp) begin bad++;
            $display("FAIL timeout fire: cyc=%0d psel=%b want %0d/0", ob_rsp_cyc, ob_psel_at_rsp, 2 + TMO); end
        total++; if (ob_err !== 1'b1 || ob_tmo !== 1'b1 || ob_rdata !== '0) begin bad++;
            $display("FAIL timeout rsp: err=%b tmo=%b rdata=%h want 1/1/0", ob_err, ob_tmo, ob_rdata); end
        run_xfer(1'b0, 32'h34, 32'h0, 4'h0, 3'b000, TMO - 1, 1'b0, 32'h0BADBEEF, 0);
        total++; if (ob_tmo !== 1'b0 || ob_err !== 1'b0 || ob_rdata !== 32'h0BADBEEF || ob_rsp_cyc != 2 + TMO) begin bad++;
            $display("FAIL timeout edge ready: tmo=%b err=%b rdata=%h cyc=%0d want 0/0/0badbeef/%0d", ob_tmo, ob_err, ob_rdata, ob_rsp_cyc, 2 + TMO); end
`else
        run_xfer(1'b0, 32'h30, 32'h0, 4'h0, 3'b000, 20, 1'b0, 32'h5A5A0001, 0);
        total++; if (ob_expired || ob_rsp_cyc != 23 || ob_tmo !== 1'b0 || ob_rdata !== 32'h5A5A0001) begin bad++;
            $display("FAIL long wait: cyc=%0d tmo=%b rdata=%h want 23/0/5a5a0001", ob_rsp_cyc, ob_tmo, ob_rdata); end
`endif
    endtask

    task automatic test_reset_mid();
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h200; cmd_wdata = 32'h77; cmd_strb = 4'h1; cmd_prot = 3'b111;
        pready = 0;
        @(negedge pclk); cmd_valid = 0;
        @(negedge pclk);
        total++; if (penable !== 1'b1) begin bad++; $display("FAIL rstmid access: penable=%b want 1", penable); end
        #1 preset = 1;
        #1;
        total++; if ({psel, penable, rsp_valid} !== 3'b000 || cmd_ready !== 1'b1) begin bad++;
            $display("FAIL rstmid drop: psel=%b penable=%b rsp_valid=%b cmd_ready=%b want 0/0/0/1", psel, penable, rsp_valid, cmd_ready); end
        total++; if (paddr !== '0 || pwdata !== '0 || pprot !== '0 || pstrb !== '0) begin bad++;
            $display("FAIL rstmid fields: paddr=%h pwdata=%h want 0", paddr, pwdata); end
        @(negedge pclk); @(negedge pclk);
        preset = 0;
        pready = 1;
        repeat (3) @(negedge pclk);
        total++; if (rsp_valid !== 1'b0 || psel !== 1'b0) begin bad++;
            $display("FAIL rstmid no response: rsp_valid=%b psel=%b want 0/0", rsp_valid, psel); end
        pready = 0;
        run_xfer(1'b1, 32'h204, 32'h99, 4'h2, 3'b000, 1, 1'b0, 32'h0, 0);
        total++; if (ob_expired || ob_rsp_cyc != 4 || ob_err !== 1'b0 || ob_field_bad != 0) begin bad++;
            $display("FAIL rstmid next write: cyc=%0d err=%b fieldbad=%0d want 4/0/0", ob_rsp_cyc, ob_err, ob_field_bad); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            logic wr, err;
            logic [AW-1:0] a;
            logic [DW-1:0] wd, rd;
            int w, bp;
            wr = 1'($urandom); err = ($urandom_range(0, 3) == 0);
            a = $urandom; wd = $urandom; rd = $urandom;
            w = $urandom_range(0, 6); bp = $urandom_range(0, 3);
            run_xfer(wr, a, wd, DW/8'($urandom), 3'($urandom), w, err, rd, bp);
            total++; if (ob_expired || ob_rsp_cyc != exp_lat(w) || ob_field_bad != 0 || ob_hold_bad != 0 || !ob_after_ok) begin bad++;
                $display("FAIL rand%0d timing: cyc=%0d want %0d fieldbad=%0d holdbad=%0d after=%0d", i, ob_rsp_cyc, exp_lat(w), ob_field_bad, ob_hold_bad, ob_after_ok); end
            total++; if (ob_tmo !== exp_tmo(w) || ob_err !== (err || exp_tmo(w)) ||
                         ob_rdata !== ((!wr && !err && !exp_tmo(w)) ? rd : '0)) begin bad++;
                $display("FAIL rand%0d rsp: rdata=%h err=%b tmo=%b (wr=%b waits=%0d slverr=%b prdata=%h)", i, ob_rdata, ob_err, ob_tmo, wr, w, err, rd); end
        end
    endtask

    initial begin
        preset = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
        cmd_strb = '0; cmd_prot = '0; rsp_ready = 0; pready = 0; pslverr = 0; prdata = '0;
        @(negedge pclk);
        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_slverr();
        test_backpressure();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
